// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the register file write port
// and the issue-stage hazard queries.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr_0;
    logic [DATA_W-1:0] req_data_0;
    logic [ADDR_W-1:0] req_addr_1;
    logic [DATA_W-1:0] req_data_1;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] query_addr_0;
    logic [ADDR_W-1:0] query_addr_1;
    logic              query_busy_0;
    logic              query_busy_1;
    logic              idle;

    modport master (
        output req_valid, req_addr_0, req_data_0, req_addr_1, req_data_1,
        output query_addr_0, query_addr_1,
        input  req_ready, rf_write_en, rf_write_addr, rf_write_data,
        input  query_busy_0, query_busy_1, idle
    );

    modport slave (
        input  req_valid, req_addr_0, req_data_0, req_addr_1, req_data_1,
        input  query_addr_0, query_addr_1,
        output req_ready, rf_write_en, rf_write_addr, rf_write_data,
        output query_busy_0, query_busy_1, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file write port: one holding slot
// per source, round-robin or fixed-priority grant, registered write, RAW queries.
module regfile_wb_arbiter #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    logic [1:0]        slot_v;
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];
    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic [1:0]        xfer;
    logic              last_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign in_addr[0] = bus.req_addr_0;
    assign in_addr[1] = bus.req_addr_1;
    assign in_data[0] = bus.req_data_0;
    assign in_data[1] = bus.req_data_1;

    // Grant depends only on slot occupancy, so ready never combinationally follows valid.
    always_comb begin
        grant = 2'b00;
        case (slot_v)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (FIXED_PRIORITY)
                    grant = 2'b10;
                else
                    grant = last_grant ? 2'b01 : 2'b10;
            end
            default: grant = 2'b00;
        endcase
    end

    assign ready    = ~slot_v | grant;
    assign xfer     = bus.req_valid & ready;
    assign sel_addr = grant[1] ? slot_addr[1] : slot_addr[0];
    assign sel_data = grant[1] ? slot_data[1] : slot_data[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v       <= 2'b00;
            slot_addr[0] <= '0;
            slot_addr[1] <= '0;
            slot_data[0] <= '0;
            slot_data[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (xfer[i]) begin
                    slot_v[i]    <= 1'b1;
                    slot_addr[i] <= in_addr[i];
                    slot_data[i] <= in_data[i];
                end else if (grant[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (grant != 2'b00)
            last_grant <= grant[1];
    end

    // A write to r0 is drained from its slot but never reaches the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (grant != 2'b00) begin
            wr_en   <= (sel_addr != '0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en <= 1'b0;
        end
    end

    assign bus.req_ready     = ready;
    assign bus.rf_write_en   = wr_en;
    assign bus.rf_write_addr = wr_addr;
    assign bus.rf_write_data = wr_data;
    assign bus.idle          = (slot_v == 2'b00) && !wr_en;

    assign bus.query_busy_0 = (bus.query_addr_0 != '0) &&
                              ((slot_v[0] && (slot_addr[0] == bus.query_addr_0)) ||
                               (slot_v[1] && (slot_addr[1] == bus.query_addr_0)) ||
                               (wr_en && (wr_addr == bus.query_addr_0)));
    assign bus.query_busy_1 = (bus.query_addr_1 != '0) &&
                              ((slot_v[0] && (slot_addr[0] == bus.query_addr_1)) ||
                               (slot_v[1] && (slot_addr[1] == bus.query_addr_1)) ||
                               (wr_en && (wr_addr == bus.query_addr_1)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector tables on a round-robin and a
// fixed-priority instance, hand sequences for hazards and reset, then random traffic.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rr_bus ();
    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) fp_bus ();

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .bus(rr_bus));
    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .bus(fp_bus));

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  ready;
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        idle;
    } vec_t;

    vec_t rr_vecs [12];
    vec_t fp_vecs [8];

    // Reference model: per instance, the pending entry of each source and the write in flight.
    logic        pend_v [2][2];
    logic [4:0]  pend_a [2][2];
    logic [31:0] pend_d [2][2];
    int          prev_w [2];
    logic        out_en [2];
    logic [4:0]  out_a  [2];
    logic [31:0] out_d  [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend_v[k][0] = 1'b0;
            pend_v[k][1] = 1'b0;
            prev_w[k]    = 1;
            out_en[k]    = 1'b0;
            out_a[k]     = 5'd0;
            out_d[k]     = 32'd0;
        end
    endtask

    function automatic int winner(input int k);
        int n;
        n = int'(pend_v[k][0]) + int'(pend_v[k][1]);
        if (n == 0) return -1;
        if (n == 1) return pend_v[k][0] ? 0 : 1;
        if (k == 1) return 1;
        return (prev_w[k] == 0) ? 1 : 0;
    endfunction

    function automatic logic [1:0] m_ready(input int k);
        int w;
        logic [1:0] r;
        w = winner(k);
        for (int i = 0; i < 2; i++) r[i] = !pend_v[k][i] || (w == i);
        return r;
    endfunction

    function automatic logic m_busy(input int k, input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        return (pend_v[k][0] && pend_a[k][0] == q) || (pend_v[k][1] && pend_a[k][1] == q) ||
               (out_en[k] && out_a[k] == q);
    endfunction

    task automatic model_step(input int k, input logic [1:0] v, input logic [4:0] a0,
                              input logic [31:0] d0, input logic [4:0] a1, input logic [31:0] d1);
        int w;
        logic [1:0] r;
        w = winner(k);
        r = m_ready(k);
        if (w >= 0) begin
            out_en[k]    = (pend_a[k][w] != 5'd0);
            out_a[k]     = pend_a[k][w];
            out_d[k]     = pend_d[k][w];
            prev_w[k]    = w;
            pend_v[k][w] = 1'b0;
        end else begin
            out_en[k] = 1'b0;
        end
        if (v[0] && r[0]) begin pend_v[k][0] = 1'b1; pend_a[k][0] = a0; pend_d[k][0] = d0; end
        if (v[1] && r[1]) begin pend_v[k][1] = 1'b1; pend_a[k][1] = a1; pend_d[k][1] = d1; end
    endtask

    task automatic drive(input bit fp, input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        if (fp) begin
            fp_bus.req_valid = v; fp_bus.req_addr_0 = a0; fp_bus.req_data_0 = d0;
            fp_bus.req_addr_1 = a1; fp_bus.req_data_1 = d1;
        end else begin
            rr_bus.req_valid = v; rr_bus.req_addr_0 = a0; rr_bus.req_data_0 = d0;
            rr_bus.req_addr_1 = a1; rr_bus.req_data_1 = d1;
        end
    endtask

    task automatic apply_vec(input bit fp, input vec_t t, input string tag);
        @(negedge clk);
        drive(fp, t.valid, t.a0, t.d0, t.a1, t.d1);
        #1;
        check({tag, " ready"}, 64'(fp ? fp_bus.req_ready : rr_bus.req_ready), 64'(t.ready));
        @(posedge clk);
        #1;
        check({tag, " wr_en"},   64'(fp ? fp_bus.rf_write_en   : rr_bus.rf_write_en),   64'(t.en));
        check({tag, " wr_addr"}, 64'(fp ? fp_bus.rf_write_addr : rr_bus.rf_write_addr), 64'(t.wa));
        check({tag, " wr_data"}, 64'(fp ? fp_bus.rf_write_data : rr_bus.rf_write_data), 64'(t.wd));
        check({tag, " idle"},    64'(fp ? fp_bus.idle          : rr_bus.idle),          64'(t.idle));
    endtask

    task automatic check_outs(input int k, input string tag);
        logic en, idl;
        logic [4:0] wa;
        logic [31:0] wd;
        if (k == 0) begin
            en = rr_bus.rf_write_en; wa = rr_bus.rf_write_addr; wd = rr_bus.rf_write_data; idl = rr_bus.idle;
        end else begin
            en = fp_bus.rf_write_en; wa = fp_bus.rf_write_addr; wd = fp_bus.rf_write_data; idl = fp_bus.idle;
        end
        check({tag, " wr_en"},   64'(en), 64'(out_en[k]));
        check({tag, " wr_addr"}, 64'(wa), 64'(out_a[k]));
        check({tag, " wr_data"}, 64'(wd), 64'(out_d[k]));
        check({tag, " idle"},    64'(idl),
              64'(!pend_v[k][0] && !pend_v[k][1] && !out_en[k]));
    endtask

    task automatic rand_cycle(input int c);
        logic [1:0]  v;
        logic [4:0]  a0, a1, q0, q1;
        logic [31:0] d0, d1;
        string       tag;
        @(negedge clk);
        v  = 2'($urandom_range(0, 3));
        a0 = 5'($urandom_range(0, 7));
        a1 = 5'($urandom_range(0, 7));
        d0 = $urandom;
        d1 = $urandom;
        q0 = 5'($urandom_range(0, 7));
        q1 = 5'($urandom_range(0, 7));
        drive(1'b0, v, a0, d0, a1, d1);
        drive(1'b1, v, a0, d0, a1, d1);
        rr_bus.query_addr_0 = q0; rr_bus.query_addr_1 = q1;
        fp_bus.query_addr_0 = q0; fp_bus.query_addr_1 = q1;
        #1;
        tag = $sformatf("rnd%0d", c);
        check({tag, " rr ready"}, 64'(rr_bus.req_ready),    64'(m_ready(0)));
        check({tag, " fp ready"}, 64'(fp_bus.req_ready),    64'(m_ready(1)));
        check({tag, " rr busy0"}, 64'(rr_bus.query_busy_0), 64'(m_busy(0, q0)));
        check({tag, " rr busy1"}, 64'(rr_bus.query_busy_1), 64'(m_busy(0, q1)));
        check({tag, " fp busy0"}, 64'(fp_bus.query_busy_0), 64'(m_busy(1, q0)));
        check({tag, " fp busy1"}, 64'(fp_bus.query_busy_1), 64'(m_busy(1, q1)));
        model_step(0, v, a0, d0, a1, d1);
        model_step(1, v, a0, d0, a1, d1);
        @(posedge clk);
        #1;
        check_outs(0, {tag, " rr"});
        check_outs(1, {tag, " fp"});
    endtask

    initial begin
        logic        hz_busy [5];
        logic [1:0]  hz_v [5];
        logic [4:0]  hz_a0 [5];

        rr_vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b11, 1'b0, 5'd0, 32'h0,        1'b0};
        rr_vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 2'b11, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
        rr_vecs[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 2'b11, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1};
        rr_vecs[3]  = '{2'b11, 5'd1, 32'hA1, 5'd2, 32'hB1, 2'b11, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
        rr_vecs[4]  = '{2'b11, 5'd3, 32'hA2, 5'd4, 32'hB2, 2'b10, 1'b1, 5'd2, 32'hB1, 1'b0};
        rr_vecs[5]  = '{2'b11, 5'd3, 32'hA2, 5'd6, 32'hB3, 2'b01, 1'b1, 5'd1, 32'hA1, 1'b0};
        rr_vecs[6]  = '{2'b11, 5'd8, 32'hA3, 5'd6, 32'hB3, 2'b10, 1'b1, 5'd4, 32'hB2, 1'b0};
        rr_vecs[7]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  2'b01, 1'b1, 5'd3, 32'hA2, 1'b0};
        rr_vecs[8]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  2'b11, 1'b1, 5'd6, 32'hB3, 1'b0};
        rr_vecs[9]  = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  2'b11, 1'b0, 5'd6, 32'hB3, 1'b1};
        rr_vecs[10] = '{2'b10, 5'd0, 32'h0,  5'd0, 32'h1234, 2'b11, 1'b0, 5'd6, 32'hB3,   1'b0};
        rr_vecs[11] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,    2'b11, 1'b0, 5'd0, 32'h1234, 1'b1};

        fp_vecs[0] = '{2'b11, 5'd20, 32'h120, 5'd21, 32'h121, 2'b11, 1'b0, 5'd0,  32'h0,   1'b0};
        fp_vecs[1] = '{2'b11, 5'd22, 32'h122, 5'd23, 32'h123, 2'b10, 1'b1, 5'd21, 32'h121, 1'b0};
        fp_vecs[2] = '{2'b11, 5'd22, 32'h122, 5'd24, 32'h124, 2'b10, 1'b1, 5'd23, 32'h123, 1'b0};
        fp_vecs[3] = '{2'b11, 5'd22, 32'h122, 5'd25, 32'h125, 2'b10, 1'b1, 5'd24, 32'h124, 1'b0};
        fp_vecs[4] = '{2'b01, 5'd22, 32'h122, 5'd0,  32'h0,   2'b10, 1'b1, 5'd25, 32'h125, 1'b0};
        fp_vecs[5] = '{2'b01, 5'd22, 32'h122, 5'd0,  32'h0,   2'b11, 1'b1, 5'd20, 32'h120, 1'b0};
        fp_vecs[6] = '{2'b00, 5'd0,  32'h0,   5'd0,  32'h0,   2'b11, 1'b1, 5'd22, 32'h122, 1'b0};
        fp_vecs[7] = '{2'b00, 5'd0,  32'h0,   5'd0,  32'h0,   2'b11, 1'b0, 5'd22, 32'h122, 1'b1};

        hz_v    = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
        hz_a0   = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd0};
        hz_busy = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0};

        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drive(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rr_bus.query_addr_0 = 5'd0; rr_bus.query_addr_1 = 5'd0;
        fp_bus.query_addr_0 = 5'd0; fp_bus.query_addr_1 = 5'd0;

        // Reset state
        #12;
        check("reset wr_en",   64'(rr_bus.rf_write_en),   64'(1'b0));
        check("reset wr_addr", 64'(rr_bus.rf_write_addr), 64'(5'd0));
        check("reset wr_data", 64'(rr_bus.rf_write_data), 64'(32'd0));
        check("reset idle",    64'(rr_bus.idle),          64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset ready", 64'(rr_bus.req_ready), 64'(2'b11));

        // Single write, alternation, and the silent r0 write
        for (int i = 0; i < 12; i++) apply_vec(1'b0, rr_vecs[i], $sformatf("rr_vec%0d", i));

        // Requester 1 holds r7 while requester 0 streams
        rr_bus.query_addr_0 = 5'd7;
        rr_bus.query_addr_1 = 5'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, hz_v[i], hz_a0[i], 32'h300 + 32'(i), 5'd7, 32'h77);
            #1;
            check($sformatf("hazard%0d busy(7)", i), 64'(rr_bus.query_busy_0), 64'(hz_busy[i]));
            check($sformatf("hazard%0d busy(0)", i), 64'(rr_bus.query_busy_1), 64'(1'b0));
            @(posedge clk);
            #1;
            if (i == 2) begin
                check("hazard r7 wr_en",   64'(rr_bus.rf_write_en),   64'(1'b1));
                check("hazard r7 wr_addr", 64'(rr_bus.rf_write_addr), 64'(5'd7));
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        end
        rr_bus.query_addr_0 = 5'd0;

        // Reset mid-cycle with both slots full and a write in flight
        @(negedge clk);
        drive(1'b0, 2'b11, 5'd14, 32'h14, 5'd15, 32'h15);
        @(negedge clk);
        drive(1'b0, 2'b11, 5'd16, 32'h16, 5'd17, 32'h17);
        @(negedge clk);
        check("pre-reset wr_en", 64'(rr_bus.rf_write_en), 64'(1'b1));
        drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("mid reset wr_en",   64'(rr_bus.rf_write_en),   64'(1'b0));
        check("mid reset wr_addr", 64'(rr_bus.rf_write_addr), 64'(5'd0));
        check("mid reset wr_data", 64'(rr_bus.rf_write_data), 64'(32'd0));
        check("mid reset idle",    64'(rr_bus.idle),          64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release ready", 64'(rr_bus.req_ready), 64'(2'b11));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("after reset%0d wr_en", i), 64'(rr_bus.rf_write_en), 64'(1'b0));
        end

        // Fixed priority: requester 0 starves until requester 1 drops
        for (int i = 0; i < 8; i++) apply_vec(1'b1, fp_vecs[i], $sformatf("fp_vec%0d", i));

        // Random traffic against the model on both instances
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 1500; c++) rand_cycle(c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
